// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// The initiator holds req and the request fields until it samples ready=1.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [3:0]  be;
  logic [31:0] dReadData;
  logic        ready;
  logic        err;

  modport master (
    output req, we, dAddress, dWriteData, be,
    input  dReadData, ready, err
  );

  modport slave (
    input  req, we, dAddress, dWriteData, be,
    output dReadData, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with configurable wait states, range/alignment error
// responses, byte-enabled writes and a saturating completed-access counter.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_responder_if.slave       bus,
  output logic [15:0]           acc_count
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  // 33-bit bounds so that accesses near 32'hFFFFFFFF cannot wrap back into range.
  localparam logic [32:0] BaseExt  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LimitExt = BaseExt + 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q;
  logic [15:0]       acc_count_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [IdxW+1:0]   offset;
  logic [IdxW-1:0]   req_idx;
  logic              unused_offset;
  logic              addr_err;

  logic              acc_en;
  logic              acc_we;
  logic [IdxW-1:0]   acc_idx;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              mem_we;
  logic              mem_re;

  assign offset        = bus.dAddress[IdxW+1:0] - BASE_ADDR[IdxW+1:0];
  assign req_idx       = offset[IdxW+1:2];
  assign unused_offset = ^offset[1:0];
  assign addr_err      = (bus.dAddress[1:0] != 2'b00)
                      || ({1'b0, bus.dAddress} <  BaseExt)
                      || ({1'b0, bus.dAddress} >= LimitExt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = 1'b0;
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = req_idx;
          wdata_d = bus.dWriteData;
          be_d    = bus.be;
          if (addr_err) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (WAIT_STATES == 0) begin
            // Zero wait states: access straight from the bus at the accept edge.
            acc_en    = 1'b1;
            acc_we    = bus.we;
            acc_idx   = req_idx;
            acc_wdata = bus.dWriteData;
            acc_be    = bus.be;
            state_d   = StResp;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Storage has no reset; gate with rst so nothing lands while reset is held.
  assign mem_we = acc_en & acc_we & rst;
  assign mem_re = acc_en & ~acc_we;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      acc_count_q <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      if (mem_re) rdata_q <= mem[acc_idx];
      if (acc_en && (acc_count_q != 16'hFFFF)) acc_count_q <= acc_count_q + 16'd1;
    end
  end

  assign bus.ready     = (state_q == StResp);
  assign bus.err       = err_q;
  assign bus.dReadData = rdata_q;
  assign acc_count     = acc_count_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-002 Parameter: DEPTH_WORDS, default 256, number of 32-bit storage words (power of two, at least 4).
REQ-003 Parameter: WAIT_STATES, default 2, extra cycles before each access completes (0..15).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 Port: req  input  1  initiator request valid.
REQ-007 Port: we  input  1  1 = write, 0 = read; qualified by req.
REQ-008 Port: dAddress  input  32  byte address of the access.
REQ-009 Port: dWriteData  input  32  store data.
REQ-010 Port: be  input  4  byte enables for writes; be[i] selects bits 8i+7:8i; ignored on reads.
REQ-011 Port: dReadData  output  32  registered load data.
REQ-012 Port: ready  output  1  one-cycle completion pulse.
REQ-013 Port: err  output  1  error flag, valid only while ready=1.
REQ-014 Port: acc_count  output  16  count of successfully completed accesses.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; the state register is the only source of ready (ready = state==RESP, glitch-free).
REQ-016 Accept: in IDLE with req=1 at a rising edge, latch we, dAddress, dWriteData and be; requests in WAIT or RESP are ignored.
REQ-017 Error check at accept: err_pending = (dAddress[1:0] != 0) OR dAddress < BASE_ADDR OR dAddress >= BASE_ADDR + 4*DEPTH_WORDS, using 33-bit arithmetic with no wrap.
REQ-018 Error path: go IDLE -> RESP directly with err=1, no storage access, dReadData unchanged, acc_count unchanged.
REQ-019 Non-error, WAIT_STATES=0: access performed at the accept edge, then IDLE -> RESP.
REQ-020 Non-error, WAIT_STATES>0: load cnt=WAIT_STATES, go to WAIT, decrement cnt each edge; at the edge where cnt==1, perform the access and go WAIT -> RESP.
REQ-021 Latency: ready=1 exactly during the cycle after edge (accept + WAIT_STATES); error responses always arrive one cycle after accept.
REQ-022 RESP lasts exactly one cycle, then returns to IDLE unconditionally; the earliest next accept is the edge ending the cycle after ready.
REQ-023 Handshake: the initiator holds req and its request fields stable until it samples ready=1, then drops req or presents a new request; the block never relies on stability after accept.
REQ-024 Word index = (dAddress - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-025 Write: update only the bytes with be[i]=1; be=4'b0000 is a legal no-op that still completes with err=0 and counts.
REQ-026 Read: dReadData is loaded at the access edge with the full word; it holds its value until the next successful read.
REQ-027 Read-after-write to the same word returns the written bytes merged with the old unenabled bytes.
REQ-028 acc_count increments by 1 at every successful access edge and saturates at 16'hFFFF.
REQ-029 err=0 whenever ready=0.

Reset
REQ-030 rst=0 asynchronously forces: state=IDLE, cnt=0, ready=0, err=0, dReadData=32'h0, acc_count=0.
REQ-031 Reset asserted in WAIT aborts the access: no storage write occurs and no ready is issued after reset release.
REQ-032 Storage contents are not reset; they are undefined until written.
REQ-033 The first accept is possible at the first rising edge with rst=1.

Verification
REQ-034 Write/read, WAIT_STATES=2: write 32'hDEADBEEF, be=4'hF, to 32'h10010010; read the same address -> ready 3 cycles after accept for each access, dReadData=32'hDEADBEEF, err=0, acc_count=2.
REQ-035 Byte enables: word holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101; read -> 32'h11BB33DD.
REQ-036 Errors: reads of 32'h10010002 (misaligned), 32'h10010400 (one past end) and 32'h1000FFFC (below base) -> each gets ready 1 cycle after accept with err=1, and dReadData and acc_count are unchanged.
REQ-037 Reset mid-access: write 32'h12345678 to 32'h10010000 and assert rst in WAIT -> ready never pulses; a later read returns the prior contents, and acc_count=0.
REQ-038 Back-to-back with WAIT_STATES=0: hold req=1 with reads of successive words -> ready pulses every 2 cycles and never on consecutive cycles.
REQ-039 Saturation: preload acc_count to 16'hFFFE by forcing it, then perform 3 writes -> acc_count stays at 16'hFFFF.
